key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/io_pkg.sv | 20 ++
 rtl/key_debounce_fsm.sv | 135 +++++++++++++
 rtl/key_debounce.sv | 35 +++
 tb/tb_key_debounce.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the key debounce block: per-key state encoding,
// default parameter values and the counter-width helper.
package io_pkg;

    localparam int DEFAULT_KEYS         = 5;
    localparam int DEFAULT_STABLE_TICKS = 10;   // 10 x 2 ms tick = 20 ms

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } deb_state_t;

    // Counter must hold 0..stable_ticks inclusive.
    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// Single-key debouncer: 2-flop synchronizer, four-state FSM advanced only on
// tick strobes, agreement counter, and registered level/press/release outputs.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// ST_IDLE        | debounced released, sample agrees with released
// ST_PRESS_CHK   | released, counting consecutive pressed samples
// ST_HELD        | debounced pressed, sample agrees with pressed
// ST_RELEASE_CHK | pressed, counting consecutive released samples
module key_debounce_fsm
    import io_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter bit KEY_ACTIVE   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int             CW  = cnt_width(STABLE_TICKS);
    localparam logic [CW:0]    LIM = (CW + 1)'(STABLE_TICKS);
    localparam logic           RELEASED_RAW = ~KEY_ACTIVE;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    deb_state_t    r_state;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    logic          w_sample;
    logic [CW:0]   w_cnt_inc;
    logic          w_reach;

    // Sample normalised so that 1 always means pressed.
    assign w_sample  = r_sync[1] ~^ KEY_ACTIVE;
    // One extra bit so the compare cannot wrap; r_cnt is 0 in IDLE/HELD,
    // which makes STABLE_TICKS = 1 jump straight across without a CHK state.
    assign w_cnt_inc = {1'b0, r_cnt} + (CW + 1)'(1);
    assign w_reach   = (w_cnt_inc >= LIM);

    // Two-flop synchronizer for the asynchronous key pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {2{RELEASED_RAW}};
        end else begin
            r_sync <= {r_sync[0], key_raw};
        end
    end

    // Debounce FSM with counter and registered outputs; advances on ticks only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (tick_in) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_sample) begin
                            if (w_reach) begin
                                r_state <= ST_HELD;
                                r_cnt   <= '0;
                                r_level <= 1'b1;
                                r_press <= 1'b1;
                            end else begin
                                r_state <= ST_PRESS_CHK;
                                r_cnt   <= w_cnt_inc[CW-1:0];
                            end
                        end
                    end
                    ST_PRESS_CHK: begin
                        if (!w_sample) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else if (w_reach) begin
                            r_state <= ST_HELD;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt   <= w_cnt_inc[CW-1:0];
                        end
                    end
                    ST_HELD: begin
                        if (!w_sample) begin
                            if (w_reach) begin
                                r_state   <= ST_IDLE;
                                r_cnt     <= '0;
                                r_level   <= 1'b0;
                                r_release <= 1'b1;
                            end else begin
                                r_state <= ST_RELEASE_CHK;
                                r_cnt   <= w_cnt_inc[CW-1:0];
                            end
                        end
                    end
                    ST_RELEASE_CHK: begin
                        if (w_sample) begin
                            r_state <= ST_HELD;
                            r_cnt   <= '0;
                        end else if (w_reach) begin
                            r_state   <= ST_IDLE;
                            r_cnt     <= '0;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt     <= w_cnt_inc[CW-1:0];
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: one independent key_debounce_fsm per key input, all
// sharing the system clock, reset and the periodic sample tick.
module key_debounce
    import io_pkg::*;
#(
    parameter int KEYS         = DEFAULT_KEYS,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter bit KEY_ACTIVE   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_in,
    input  logic [KEYS-1:0] key_raw,
    output logic [KEYS-1:0] key_level,
    output logic [KEYS-1:0] key_press,
    output logic [KEYS-1:0] key_release
);

    // One debouncer per key; keys never interact.
    for (genvar g = 0; g < KEYS; g++) begin : g_key
        key_debounce_fsm #(
            .STABLE_TICKS (STABLE_TICKS),
            .KEY_ACTIVE   (KEY_ACTIVE)
        ) u_key (
            .clk         (clk),
            .rst         (rst),
            .tick_in     (tick_in),
            .key_raw     (key_raw[g]),
            .key_level   (key_level[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with KEYS=2, STABLE_TICKS=3, active-high keys.
// A run-length reference model queues expected pulses; a monitor pops them
// when the DUT pulses and checks the level every cycle.
module tb_key_debounce;

    localparam int KEYS   = 2;
    localparam int STABLE = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick_in = 1'b0;
    logic [KEYS-1:0] key_raw = '0;
    logic [KEYS-1:0] key_level;
    logic [KEYS-1:0] key_press;
    logic [KEYS-1:0] key_release;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [KEYS-1:0] pr;
        logic [KEYS-1:0] rl;
    } ev_t;

    ev_t q[$];

    // reference model state
    logic [KEYS-1:0] m_level = '0;
    int              m_run[KEYS];
    logic [KEYS-1:0] m_d1 = '0;
    logic [KEYS-1:0] m_d2 = '0;

    key_debounce #(
        .KEYS         (KEYS),
        .STABLE_TICKS (STABLE),
        .KEY_ACTIVE   (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_in     (tick_in),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    // Reference: a key flips its debounced level once STABLE consecutive tick
    // samples disagree with it; samples are the pin delayed by two clocks.
    always @(posedge clk) begin
        ev_t e;
        if (rst) begin
            m_level = '0;
            for (int k = 0; k < KEYS; k++) m_run[k] = 0;
            m_d1 = '0;
            m_d2 = '0;
        end else begin
            if (tick_in) begin
                e.pr = '0;
                e.rl = '0;
                for (int k = 0; k < KEYS; k++) begin
                    if (m_d2[k] != m_level[k]) begin
                        m_run[k] = m_run[k] + 1;
                        if (m_run[k] == STABLE) begin
                            m_level[k] = m_d2[k];
                            m_run[k]   = 0;
                            if (m_d2[k]) e.pr[k] = 1'b1;
                            else         e.rl[k] = 1'b1;
                        end
                    end else begin
                        m_run[k] = 0;
                    end
                end
                if ((e.pr | e.rl) != '0) q.push_back(e);
            end
            m_d2 = m_d1;
            m_d1 = key_raw;
        end
    end

    // Monitor: level every cycle, pulses against the scoreboard queue.
    always @(negedge clk) begin
        ev_t e;
        total++;
        if (key_level !== m_level) begin
            bad++;
            $display("FAIL level: got %b want %b t=%0t", key_level, m_level, $time);
        end
        if (key_press != '0 || key_release != '0 || q.size() != 0) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: press=%b release=%b want none t=%0t",
                         key_press, key_release, $time);
            end else begin
                e = q.pop_front();
                if (key_press !== e.pr || key_release !== e.rl) begin
                    bad++;
                    $display("FAIL pulse: press=%b release=%b want press=%b release=%b t=%0t",
                             key_press, key_release, e.pr, e.rl, $time);
                end
            end
        end
    end

    task automatic step(input logic [KEYS-1:0] raw, input logic tk, input logic r);
        key_raw = raw;
        tick_in = tk;
        rst     = r;
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n, input logic [KEYS-1:0] raw);
        repeat (n) step(raw, (cyc % 4) == 3, 1'b0);
    endtask

    initial begin
        logic [KEYS-1:0] snap;
        logic [KEYS-1:0] rnd;
        logic            tk;

        // reset
        repeat (3) step('0, 1'b0, 1'b1);
        total++;
        if ({key_level, key_press, key_release} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {key_level, key_press, key_release});
        end
        run(20, 2'b00);

        // key 0 held: press after 3 agreeing ticks, key 1 untouched
        run(24, 2'b01);
        // release with a one-tick glitch restarting the count
        run(8, 2'b00);
        run(4, 2'b01);
        run(24, 2'b00);

        // short burst (2 ticks) then valid burst
        run(8, 2'b01);
        run(4, 2'b00);
        run(20, 2'b01);
        run(24, 2'b00);

        // both keys together
        run(24, 2'b11);
        run(24, 2'b00);

        // reset after two agreeing ticks discards progress
        run(10, 2'b01);
        step(2'b01, 1'b0, 1'b1);
        total++;
        if ({key_level, key_press, key_release} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got %b want 0", {key_level, key_press, key_release});
        end
        run(24, 2'b01);

        // no ticks for 100 cycles while pins toggle
        snap = m_level;
        for (int i = 0; i < 100; i++) step(KEYS'($urandom), 1'b0, 1'b0);
        total++;
        if (key_level !== snap) begin
            bad++;
            $display("FAIL no_tick_hold: got %b want %b", key_level, snap);
        end
        run(24, 2'b00);

        // random bouncing, tick bursts and occasional reset
        rnd = '0;
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < KEYS; k++)
                if ($urandom_range(0, 11) == 0) rnd[k] = ~rnd[k];
            if ($urandom_range(0, 19) == 0) tk = 1'b1;
            else                           tk = (cyc % 4) == 3;
            step(rnd, tk, $urandom_range(0, 599) == 0);
        end

        run(40, 2'b00);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected pulses never seen, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
